// File: rtl/iecdrv_sd_responder.sv
// Serves drive-buffer block requests byte by byte from a backing image; one mem access per in-image byte.
// Latency: sd_ack one cycle after accept; mem_rd/mem_wr held until mem_ready, so memory stalls pause the transfer.
module iecdrv_sd_responder #(
  parameter int BLK_SHIFT = 8,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       i_img_size,
  input  logic [31:0]       i_sd_lba,
  input  logic [5:0]        i_sd_blk_cnt,
  input  logic              i_sd_rd,
  input  logic              i_sd_wr,
  output logic              o_sd_ack,
  output logic [ADDR_W-1:0] o_sd_buff_addr,
  output logic [7:0]        o_sd_buff_dout,
  output logic              o_sd_buff_wr,
  input  logic [7:0]        i_sd_buff_din,
  output logic [31:0]       o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata,
  input  logic              i_mem_ready
);

  typedef enum logic [2:0] {
    IDLE, RD_MEM, RD_PUT, WR_ADDR, WR_CAP, WR_MEM, NEXT, DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_lba;
  logic [15:0] r_len_m1;
  logic [15:0] r_off;
  logic        r_is_wr;
  logic        r_armed;

  logic [15:0] w_len;
  logic [31:0] w_byte_addr;
  logic        w_in_img;
  logic [15:0] w_off_nxt;

  assign w_len       = ({10'd0, i_sd_blk_cnt} + 16'd1) << BLK_SHIFT;
  assign w_byte_addr = (r_lba << BLK_SHIFT) + {16'd0, r_off};
  assign w_in_img    = (w_byte_addr < i_img_size);
  assign w_off_nxt   = r_off + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_lba          <= '0;
      r_len_m1       <= '0;
      r_off          <= '0;
      r_is_wr        <= 1'b0;
      r_armed        <= 1'b1;
      o_sd_ack       <= 1'b0;
      o_sd_buff_addr <= '0;
      o_sd_buff_dout <= '0;
      o_sd_buff_wr   <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_rd       <= 1'b0;
      o_mem_wr       <= 1'b0;
      o_mem_wdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // r_armed stays low after a transfer until both request levels have dropped
          if (r_armed && (i_sd_rd || i_sd_wr)) begin
            r_lba    <= i_sd_lba;
            r_len_m1 <= w_len - 16'd1;
            r_off    <= '0;
            r_is_wr  <= !i_sd_rd;
            r_armed  <= 1'b0;
            o_sd_ack <= 1'b1;
            if (i_sd_rd) begin
              r_state <= RD_MEM;
            end else begin
              o_sd_buff_addr <= '0;
              r_state        <= WR_ADDR;
            end
          end else if (!i_sd_rd && !i_sd_wr) begin
            r_armed <= 1'b1;
          end
        end
        RD_MEM: begin
          if (!o_mem_rd) begin
            if (w_in_img) begin
              o_mem_rd   <= 1'b1;
              o_mem_addr <= w_byte_addr;
            end else begin
              o_sd_buff_dout <= 8'h00;
              o_sd_buff_addr <= ADDR_W'(r_off);
              o_sd_buff_wr   <= 1'b1;
              r_state        <= RD_PUT;
            end
          end else if (i_mem_ready) begin
            o_mem_rd       <= 1'b0;
            o_sd_buff_dout <= i_mem_rdata;
            o_sd_buff_addr <= ADDR_W'(r_off);
            o_sd_buff_wr   <= 1'b1;
            r_state        <= RD_PUT;
          end
        end
        RD_PUT: begin
          o_sd_buff_wr <= 1'b0;
          r_state      <= NEXT;
        end
        WR_ADDR: begin
          r_state <= WR_CAP;
        end
        WR_CAP: begin
          // buffer data lags the address by one cycle, so it is valid here
          o_mem_wdata <= i_sd_buff_din;
          if (w_in_img) begin
            o_mem_wr   <= 1'b1;
            o_mem_addr <= w_byte_addr;
            r_state    <= WR_MEM;
          end else begin
            r_state <= NEXT;
          end
        end
        WR_MEM: begin
          if (i_mem_ready) begin
            o_mem_wr <= 1'b0;
            r_state  <= NEXT;
          end
        end
        NEXT: begin
          if (r_off == r_len_m1) begin
            r_state <= DONE;
          end else begin
            r_off <= w_off_nxt;
            if (r_is_wr) begin
              o_sd_buff_addr <= ADDR_W'(w_off_nxt);
              r_state        <= WR_ADDR;
            end else begin
              r_state <= RD_MEM;
            end
          end
        end
        DONE: begin
          o_sd_ack <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iecdrv_sd_responder.sv
// Bench for iecdrv_sd_responder: vector table plus random transfers against a per-byte image/buffer model.
// Memory responder with programmable wait states; drive buffer modelled as a one-cycle-latency RAM.
module tb_iecdrv_sd_responder;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       img;
  logic [31:0]       i_sd_lba;
  logic [5:0]        i_sd_blk_cnt;
  logic              i_sd_rd, i_sd_wr;
  logic              o_sd_ack;
  logic [ADDR_W-1:0] o_sd_buff_addr;
  logic [7:0]        o_sd_buff_dout;
  logic              o_sd_buff_wr;
  logic [7:0]        din;
  logic [31:0]       o_mem_addr;
  logic              o_mem_rd, o_mem_wr;
  logic [7:0]        o_mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  always #5 clk = ~clk;

  iecdrv_sd_responder #(.BLK_SHIFT(8), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .i_img_size(img), .i_sd_lba(i_sd_lba),
    .i_sd_blk_cnt(i_sd_blk_cnt), .i_sd_rd(i_sd_rd), .i_sd_wr(i_sd_wr),
    .o_sd_ack(o_sd_ack), .o_sd_buff_addr(o_sd_buff_addr), .o_sd_buff_dout(o_sd_buff_dout),
    .o_sd_buff_wr(o_sd_buff_wr), .i_sd_buff_din(din), .o_mem_addr(o_mem_addr),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready)
  );

  typedef struct {
    bit          is_rd;
    bit          both;
    logic [31:0] lba;
    logic [5:0]  cnt;
    logic [31:0] img;
    int          lat;
    int          exp_buf;
    int          exp_mem;   // -1: take the count from the model
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } rec_t;

  rec_t rd_q[$];
  rec_t wr_q[$];
  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mem_rd_cnt = 0;
  int   viol = 0;
  int   ack_rises = 0;
  int   lat = 0;
  bit   cur_is_wr = 1'b0;

  function automatic logic [7:0] mf(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] bf(input logic [15:0] x);
    return {x[3:0], x[7:4]} ^ x[15:8] ^ 8'hC3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Memory responder, drive-buffer model and protocol monitor, all evaluated mid-cycle.
  initial begin
    logic [15:0] prev_baddr;
    logic [31:0] prev_maddr;
    bit          prev_hold, prev_bwr, prev_ack;
    int          wcnt;
    prev_baddr = '0; prev_maddr = '0; prev_hold = 0; prev_bwr = 0; prev_ack = 0; wcnt = 0;
    mem_ready = 1'b0; mem_rdata = 8'h00; din = 8'h00;
    forever begin
      @(negedge clk);
      din = bf(prev_baddr);
      prev_baddr = o_sd_buff_addr;
      if (o_mem_rd === 1'b1 || o_mem_wr === 1'b1) begin
        if (wcnt >= lat) begin
          mem_ready = 1'b1; wcnt = 0; mem_rdata = mf(o_mem_addr);
        end else begin
          mem_ready = 1'b0; wcnt++; mem_rdata = 8'($urandom);
        end
      end else begin
        mem_ready = 1'b0; wcnt = 0;
      end
      if (o_mem_rd === 1'b1 && o_mem_wr === 1'b1) viol++;
      if ((o_mem_rd === 1'b1 || o_mem_wr === 1'b1) && o_mem_addr >= img) viol++;
      if (prev_hold && (!(o_mem_rd || o_mem_wr) || o_mem_addr !== prev_maddr)) viol++;
      prev_hold  = (o_mem_rd === 1'b1 || o_mem_wr === 1'b1) && !mem_ready;
      prev_maddr = o_mem_addr;
      if (o_mem_rd === 1'b1 && mem_ready) mem_rd_cnt++;
      if (o_mem_wr === 1'b1 && mem_ready) wr_q.push_back({o_mem_addr, o_mem_wdata});
      if (o_sd_buff_wr === 1'b1) begin
        rd_q.push_back({16'd0, o_sd_buff_addr, o_sd_buff_dout});
        if (cur_is_wr || prev_bwr) viol++;
      end
      prev_bwr = (o_sd_buff_wr === 1'b1);
      if (o_sd_ack === 1'b1 && !prev_ack) ack_rises++;
      prev_ack = (o_sd_ack === 1'b1);
    end
  end

  // Reference: every byte of the transfer, straight from the image/bypass rules.
  task automatic build_expect(input vec_t v, output int exp_mem);
    int          len;
    logic [31:0] a;
    len = (int'(v.cnt) + 1) * 256;
    exp_q.delete();
    exp_mem = 0;
    for (int off = 0; off < len; off++) begin
      a = v.lba * 32'd256 + 32'(off);
      if (v.is_rd) begin
        exp_q.push_back({16'd0, 16'(off), (a < v.img) ? mf(a) : 8'h00});
        if (a < v.img) exp_mem++;
      end else if (a < v.img) begin
        exp_q.push_back({a, bf(16'(off))});
        exp_mem++;
      end
    end
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    int n, len, model_mem, mism, obs_mem;
    len = (int'(v.cnt) + 1) * 256;
    @(negedge clk);
    img = v.img; lat = v.lat; cur_is_wr = !v.is_rd;
    rd_q.delete(); wr_q.delete(); mem_rd_cnt = 0; viol = 0; ack_rises = 0;
    i_sd_lba = v.lba; i_sd_blk_cnt = v.cnt;
    i_sd_rd = v.is_rd; i_sd_wr = !v.is_rd || v.both;
    n = 0;
    while (o_sd_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_ack_rise"}, o_sd_ack, 1);
    // request fields wander during the transfer; levels stay held
    i_sd_lba = $urandom; i_sd_blk_cnt = 6'($urandom);
    n = 0;
    while (o_sd_ack !== 1'b0 && n < len * (v.lat + 8) + 100) begin @(negedge clk); n++; end
    chk({tag, "_ack_fall"}, o_sd_ack, 0);
    repeat (6) @(negedge clk);
    i_sd_rd = 1'b0; i_sd_wr = 1'b0;
    repeat (2) @(negedge clk);
    build_expect(v, model_mem);
    obs_mem = v.is_rd ? mem_rd_cnt : wr_q.size();
    chk({tag, "_single_xfer"}, ack_rises, 1);
    chk({tag, "_buf_wr_count"}, rd_q.size(), v.exp_buf);
    chk({tag, "_mem_count"}, obs_mem, (v.exp_mem < 0) ? model_mem : v.exp_mem);
    mism = 0;
    if (v.is_rd) begin
      if (rd_q.size() != exp_q.size()) mism = 1;
      else foreach (exp_q[i]) if (rd_q[i] !== exp_q[i]) mism++;
    end else begin
      if (wr_q.size() != exp_q.size()) mism = 1;
      else foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) mism++;
    end
    chk({tag, "_data_mismatches"}, mism, 0);
    chk({tag, "_protocol_violations"}, viol, 0);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t rv;
    int   n;
    tbl[0] = '{1, 0, 32'd2,          6'd0,  32'd16384,      0, 256, 256};
    tbl[1] = '{0, 0, 32'd0,          6'd51, 32'd16384,      0, 0,   13312};
    tbl[2] = '{1, 0, 32'd1,          6'd0,  32'd300,        1, 256, 44};
    tbl[3] = '{1, 1, 32'd3,          6'd0,  32'd16384,      5, 256, 256};
    tbl[4] = '{1, 0, 32'h00FF_FFFF,  6'd1,  32'hFFFF_FFFF,  0, 512, 511};
    tbl[5] = '{0, 0, 32'd1,          6'd0,  32'd300,        2, 0,   44};
    tbl[6] = '{0, 0, 32'd5,          6'd0,  32'd0,          0, 0,   0};
    tbl[7] = '{1, 0, 32'd0,          6'd0,  32'd0,          0, 256, 0};

    reset = 1'b1; img = 32'd0; i_sd_lba = '0; i_sd_blk_cnt = '0; i_sd_rd = 1'b0; i_sd_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", o_sd_ack, 0);
    chk("rst_buff_wr", o_sd_buff_wr, 0);
    chk("rst_mem_rd", o_mem_rd, 0);
    chk("rst_mem_wr", o_mem_wr, 0);
    chk("rst_buff_addr", o_sd_buff_addr, 0);
    chk("rst_buff_dout", o_sd_buff_dout, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_wdata", o_mem_wdata, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_xfer(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a read, then a fresh read must run from offset 0.
    @(negedge clk);
    img = 32'd16384; lat = 0; cur_is_wr = 1'b0;
    i_sd_lba = 32'd0; i_sd_blk_cnt = 6'd0; i_sd_rd = 1'b1;
    n = 0;
    while (!(o_sd_buff_wr === 1'b1 && o_sd_buff_addr == 16'd100) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("midrst_reached_byte100", o_sd_buff_addr, 100);
    reset = 1'b1; i_sd_rd = 1'b0;
    @(negedge clk);
    chk("midrst_ack", o_sd_ack, 0);
    chk("midrst_mem_rd", o_mem_rd, 0);
    chk("midrst_buff_wr", o_sd_buff_wr, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_stays_idle", {o_sd_ack, o_mem_rd, o_sd_buff_wr}, 0);
    run_xfer(tbl[0], "after_rst");

    for (int i = 0; i < 4; i++) begin
      rv.is_rd   = 1'($urandom_range(0, 1));
      rv.both    = rv.is_rd && ($urandom_range(0, 1) == 1);
      rv.lba     = 32'($urandom_range(0, 300));
      rv.cnt     = 6'd0;
      rv.img     = 32'($urandom_range(0, 80000));
      rv.lat     = $urandom_range(0, 2);
      rv.exp_buf = rv.is_rd ? 256 : 0;
      rv.exp_mem = -1;
      run_xfer(rv, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iecdrv_sd_responder.md
IECDRV_SD_RESPONDER -- requirements
Module: iecdrv_sd_responder

Interface
REQ-001 SHALL have parameter BLK_SHIFT, default 8, log2 of block size in bytes (256-byte blocks).
REQ-002 SHALL have parameter ADDR_W, default 16, width of sd_buff_addr.
REQ-003 clk  in  1  clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 img_size  in  32  backing image size in bytes; 0 = no image.
REQ-006 sd_lba  in  32  first block of request; sampled at accept.
REQ-007 sd_blk_cnt  in  6  block count minus one; sampled at accept.
REQ-008 sd_rd  in  1  level read request (image to drive buffer).
REQ-009 sd_wr  in  1  level write request (drive buffer to image).
REQ-010 sd_ack  out  1  high for the whole transfer.
REQ-011 sd_buff_addr  out  ADDR_W  byte offset within the transfer.
REQ-012 sd_buff_dout  out  8  read data to the drive buffer.
REQ-013 sd_buff_wr  out  1  one-cycle strobe: sd_buff_dout is valid at sd_buff_addr.
REQ-014 sd_buff_din  in  8  drive buffer data; valid 1 cycle after sd_buff_addr changes.
REQ-015 mem_addr  out  32  backing byte address = (lba<<BLK_SHIFT)+offset.
REQ-016 mem_rd / mem_wr  out  1 each  level strobes, held until mem_ready.
REQ-017 mem_wdata  out  8  write data; mem_rdata  in  8  read data, valid with mem_ready.
REQ-018 mem_ready  in  1  completes the current mem access in the cycle it is high.

Function
REQ-019 States SHALL be IDLE, RD_MEM, RD_PUT, WR_ADDR, WR_CAP, WR_MEM, NEXT, DONE.
REQ-020 In IDLE with sd_rd=1 or sd_wr=1, SHALL latch lba and blk_cnt, clear the offset and set sd_ack=1 next cycle; sd_rd SHALL take priority when both are high.
REQ-021 Transfer length SHALL be (blk_cnt+1)<<BLK_SHIFT bytes, computed in 16 bits (max 16384).
REQ-022 RD_MEM SHALL assert mem_rd with mem_addr until mem_ready, then capture mem_rdata and go to RD_PUT.
REQ-023 RD_PUT SHALL pulse sd_buff_wr for exactly 1 cycle with the captured sd_buff_addr and sd_buff_dout, then go to NEXT.
REQ-024 WR_ADDR SHALL drive sd_buff_addr=offset; WR_CAP (next cycle) SHALL capture sd_buff_din into mem_wdata; WR_MEM SHALL assert mem_wr until mem_ready.
REQ-025 A byte whose mem_addr >= img_size SHALL bypass memory: a read returns 0x00 with no mem_rd, and a write is dropped with no mem_wr.
REQ-026 In NEXT, if offset = length-1, SHALL go to DONE; otherwise SHALL increment the offset and resume RD_MEM or WR_ADDR.
REQ-027 DONE SHALL deassert sd_ack and return to IDLE.
REQ-028 A new request SHALL be accepted only after sd_rd and sd_wr have both been seen low for at least 1 cycle following DONE, so a held level never retriggers.
REQ-029 Request inputs changing during a transfer SHALL be ignored.
REQ-030 mem_addr arithmetic SHALL be 32-bit and wrap modulo 2^32 with no error.
REQ-031 mem_rd and mem_wr SHALL never be high together.
REQ-032 sd_buff_wr SHALL never be high during a write transfer.

Reset
REQ-033 Reset SHALL force IDLE, with sd_ack=0, sd_buff_wr=0, mem_rd=0, mem_wr=0, sd_buff_addr=0, sd_buff_dout=0, mem_addr=0 and mem_wdata=0.
REQ-034 Reset mid-transfer SHALL abort immediately with no further mem or buffer strobes, and SHALL clear the REQ-028 re-arm condition.

Verification
REQ-035 Read: img_size=16384, sd_lba=2, sd_blk_cnt=0, sd_rd held until sd_ack -> 256 sd_buff_wr pulses, addr 0..255, data = mem[512..767], then sd_ack falls.
REQ-036 Write: sd_lba=0, sd_blk_cnt=51, sd_wr=1 -> 13312 mem_wr strobes at addr 0..13311 with data equal to the drive buffer, and no sd_buff_wr.
REQ-037 Boundary: img_size=300, read with lba=1, blk_cnt=0 -> bytes 0..43 come from memory, bytes 44..255 are 0x00, and mem_rd never has addr >= 300.
REQ-038 Stall and priority: mem_ready delayed 5 cycles on every access, with sd_rd and sd_wr both high -> read performed, strobes held stable, data correct, and exactly one transfer until the requests drop.
REQ-039 Reset at byte 100 of a read -> next cycle sd_ack=0 and mem_rd=0; a fresh request afterwards completes normally from offset 0.
